// File: rtl/led_scan_ctrl.sv
// Multiplexed 7-segment display controller: accepts a binary word over valid/ready,
// converts it to BCD one bit per clock (double-dabble), and scans the digits.
module led_scan_ctrl #(
    parameter int DIGITS   = 8,
    parameter int DATA_W   = 27,
    parameter int SCAN_DIV = 32768,
    parameter int BLANK_LZ = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic [DIGITS-1:0] digit_sel,
    output logic [3:0]        digit_value,
    output logic              digit_blank,
    output logic              overflow
);

    localparam int BCD_W   = 4 * DIGITS;
    localparam int CNT_W   = $clog2(DATA_W + 1);
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    // Largest value representable on the panel; anything above is shown as all nines.
    localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DATA_W-1:0]  r_bin;
    logic [BCD_W-1:0]   r_bcd;
    logic [BCD_W-1:0]   w_bcd_adj;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf_pend;
    logic [BCD_W-1:0]   r_disp;
    logic               r_ovf;
    logic [PRESC_W-1:0] r_presc;
    logic [IDX_W-1:0]   r_idx;
    logic               w_accept;
    logic               w_last_step;
    logic               w_scan_tc;
    logic               w_upper_nz;

    assign w_accept    = data_valid && (r_state == IDLE);
    assign w_last_step = (r_cnt == CNT_W'(1));
    assign w_scan_tc   = (r_presc == PRESC_W'(SCAN_DIV - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // NOTE: every signal written in a combinational block gets a default first,
    // otherwise a missed branch infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        data_ready  = 1'b0;
        unique case (r_state)
            IDLE: begin
                data_ready = 1'b1;
                if (data_valid) w_state_nxt = CONV;
            end
            CONV:    if (w_last_step) w_state_nxt = COMMIT;
            COMMIT:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Add-3 correction applied to each nibble before the shift.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5) w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
        end else if (w_accept) begin
            r_bin      <= data_in;
            r_bcd      <= '0;
            r_cnt      <= CNT_W'(DATA_W);
            r_ovf_pend <= (64'(data_in) > MAX_VAL);
        end else if (r_state == CONV) begin
            r_bcd <= {w_bcd_adj[BCD_W-2:0], r_bin[DATA_W-1]};
            r_bin <= {r_bin[DATA_W-2:0], 1'b0};
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // NOTE: the display register is an ordinary flop bank, not a memory, so it takes
    // the async reset; the panel must read zero as soon as reset asserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp <= '0;
            r_ovf  <= 1'b0;
        end else if (r_state == COMMIT) begin
            r_disp <= r_ovf_pend ? {DIGITS{4'd9}} : r_bcd;
            r_ovf  <= r_ovf_pend;
        end
    end

    // Scan timing runs freely; loads never restart it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_scan_tc) begin
            r_presc <= '0;
            r_idx   <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

    always_comb begin
        digit_sel   = '0;
        digit_value = 4'd0;
        w_upper_nz  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (IDX_W'(i) == r_idx) begin
                digit_sel[i] = 1'b1;
                digit_value  = r_disp[i*4 +: 4];
            end
            if (IDX_W'(i) >= r_idx && r_disp[i*4 +: 4] != 4'd0) w_upper_nz = 1'b1;
        end
        digit_blank = (BLANK_LZ != 0) && (r_idx != '0) && !w_upper_nz;
    end

    assign overflow = r_ovf;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Randomized self-checking bench for led_scan_ctrl against a decimal-arithmetic model.
module tb_led_scan_ctrl;

    localparam int DIGITS   = 8;
    localparam int DATA_W   = 27;
    localparam int SCAN_DIV = 4;
    localparam int LATENCY  = DATA_W + 1;
    localparam longint MAX_VAL = 64'd99999999;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              data_valid = 1'b0;
    logic              data_ready;
    logic [DIGITS-1:0] digit_sel;
    logic [3:0]        digit_value;
    logic              digit_blank;
    logic              overflow;

    int     n_checks = 0;
    int     n_errors = 0;
    longint cyc = 0;
    longint acc_cyc = 0;
    longint exp_val = 0;
    bit     exp_ovf = 1'b0;

    led_scan_ctrl #(
        .DIGITS(DIGITS), .DATA_W(DATA_W), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .digit_sel(digit_sel), .digit_value(digit_value),
        .digit_blank(digit_blank), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Clock edges seen since reset release; the scan position follows from this alone.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic longint pow10(input int n);
        longint r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    task automatic scan_check(input int n);
        int     idx;
        longint e_digit;
        bit     e_blank;
        repeat (n) begin
            @(negedge clk);
            idx     = int'((cyc / SCAN_DIV) % DIGITS);
            e_digit = exp_ovf ? 9 : (exp_val / pow10(idx)) % 10;
            e_blank = !exp_ovf && idx > 0 && exp_val < pow10(idx);
            check("digit_sel", longint'(digit_sel), longint'(1) << idx);
            check("digit_value", longint'(digit_value), e_digit);
            check("digit_blank", longint'(digit_blank), longint'(e_blank));
            check("overflow", longint'(overflow), longint'(exp_ovf));
        end
    endtask

    task automatic start_load(input longint v);
        int guard = 0;
        while (!data_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_load", longint'(data_ready), 1);
        data_in    = DATA_W'(v);
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc    = cyc;
        data_valid = 1'b0;
        data_in    = DATA_W'($urandom);
        check("ready_low_after_accept", longint'(data_ready), 0);
    endtask

    task automatic finish_load(input longint v);
        int guard = 0;
        while (!data_ready && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("ready_returns", longint'(data_ready), 1);
        check("latency", cyc - acc_cyc, LATENCY);
        exp_val = v;
        exp_ovf = (v > MAX_VAL);
    endtask

    task automatic load(input longint v, input int scan_cycles);
        start_load(v);
        finish_load(v);
        scan_check(scan_cycles);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_sel"}, longint'(digit_sel), 1);
        check({tag, "_value"}, longint'(digit_value), 0);
        check({tag, "_blank"}, longint'(digit_blank), 0);
        check({tag, "_ovf"}, longint'(overflow), 0);
        check({tag, "_ready"}, longint'(data_ready), 1);
        check({tag, "_disp"}, longint'(dut.r_disp), 0);
    endtask

    initial begin
        longint v;
        #2;
        reset_checks("rst_init");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        scan_check(36);
        load(12345678, 34);
        load(0, 32);
        load(405, 32);
        load(100000000, 32);
        load(7, 32);

        for (int i = 0; i < 8; i++) begin
            if (i % 3 == 2) v = longint'($urandom) & 64'h7FFFFFF;
            else            v = longint'($urandom_range(0, 32'(pow10($urandom_range(1, 8)) - 1)));
            load(v, 8 + int'($urandom_range(0, 40)));
        end
        load(64'h7FFFFFF, 16);
        load(MAX_VAL, 16);

        // A second request during conversion must be ignored, and the panel keeps
        // the old value until the commit.
        start_load(11111111);
        data_valid = 1'b1;
        data_in    = DATA_W'(22222222);
        scan_check(20);
        data_valid = 1'b0;
        finish_load(11111111);
        scan_check(32);

        // Abort a conversion with reset.
        start_load(55555555);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_val = 0;
        exp_ovf = 1'b0;
        reset_checks("rst_abort");
        @(negedge clk);
        rst_n = 1'b1;
        scan_check(16);
        load(99999999, 32);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
